// File: rtl/vector_line_gen_if.sv
// Command channel between the display-list fetcher and vector_line_gen.
// The fetcher drives the master side; the line generator is the slave.
interface vector_line_gen_if #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned INT_W   = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_blank;
    logic [COORD_W-1:0] cmd_x0;
    logic [COORD_W-1:0] cmd_y0;
    logic [COORD_W-1:0] cmd_x1;
    logic [COORD_W-1:0] cmd_y1;
    logic [INT_W-1:0]   cmd_int;
    logic               abort;

    modport master (
        output cmd_valid, cmd_blank, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_int, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_blank, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_int, abort,
        output cmd_ready
    );
endinterface

// File: rtl/vector_line_gen.sv
// Bresenham XY beam driver: walks one line (or one blank move) per command and
// presents each point on the DAC buses for a fixed number of clocks.
module vector_line_gen #(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned INT_W    = 4,
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned SETTLE   = 16
) (
    input  logic               clkin,
    input  logic               rst_n,
    vector_line_gen_if.slave   cmd,
    output logic [COORD_W-1:0] xdac_out,
    output logic [COORD_W-1:0] ydac_out,
    output logic [INT_W-1:0]   z_out,
    output logic               state_clk_out,
    output logic               busy,
    output logic               done
);
    localparam int unsigned EW      = COORD_W + 2;
    localparam int unsigned HoldMax = (STEP_DIV > SETTLE) ? STEP_DIV : SETTLE;
    localparam int unsigned CW      = $clog2(HoldMax + 1);

    typedef logic [COORD_W-1:0] coord_t;
    typedef enum logic [1:0] {StIdle, StSetup, StDraw, StSettle} state_e;

    state_e               state_q, state_d;
    logic                 blank_q, blank_d;
    coord_t               x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [INT_W-1:0]     int_q, int_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    coord_t               x_q, x_d, y_q, y_d;
    logic [INT_W-1:0]     z_q, z_d;
    logic                 strobe_q, strobe_d, done_q, done_d;
    logic                 pend_q, pend_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    coord_t               dx_abs, dy_abs;
    logic signed [EW:0]   e2, dx_e, dy_e;

    assign cmd.cmd_ready = (state_q == StIdle) && !cmd.abort;

    always_comb begin
        dx_abs = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
        dy_abs = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;
        e2     = {err_q, 1'b0};
        dx_e   = {dx_q[EW-1], dx_q};
        dy_e   = {dy_q[EW-1], dy_q};
    end

    always_comb begin
        state_d  = state_q;
        blank_d  = blank_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        int_d    = int_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    blank_d = cmd.cmd_blank;
                    x0_d    = cmd.cmd_x0;
                    y0_d    = cmd.cmd_y0;
                    x1_d    = cmd.cmd_x1;
                    y1_d    = cmd.cmd_y1;
                    int_d   = cmd.cmd_int;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                dx_d     = signed'({2'b00, dx_abs});
                dy_d     = -signed'({2'b00, dy_abs});
                err_d    = signed'({2'b00, dx_abs}) - signed'({2'b00, dy_abs});
                sx_neg_d = x1_q < x0_q;
                sy_neg_d = y1_q < y0_q;
                pend_d   = 1'b1;
                state_d  = blank_q ? StSettle : StDraw;
            end
            StDraw: begin
                // pend_q marks the first point, which is presented without stepping
                if (pend_q) begin
                    x_d      = x0_q;
                    y_d      = y0_q;
                    z_d      = int_q;
                    strobe_d = 1'b1;
                    cnt_d    = CW'(STEP_DIV - 1);
                    pend_d   = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (x_q == x1_q && y_q == y1_q) begin
                    done_d  = 1'b1;
                    z_d     = '0;
                    state_d = StIdle;
                end else begin
                    if (e2 >= dy_e) begin
                        err_d = err_d + dy_q;
                        x_d   = sx_neg_q ? x_q - COORD_W'(1) : x_q + COORD_W'(1);
                    end
                    if (e2 <= dx_e) begin
                        err_d = err_d + dx_q;
                        y_d   = sy_neg_q ? y_q - COORD_W'(1) : y_q + COORD_W'(1);
                    end
                    strobe_d = 1'b1;
                    cnt_d    = CW'(STEP_DIV - 1);
                end
            end
            StSettle: begin
                if (pend_q) begin
                    x_d      = x1_q;
                    y_d      = y1_q;
                    z_d      = '0;
                    strobe_d = 1'b1;
                    cnt_d    = CW'(SETTLE - 1);
                    pend_d   = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort leaves the beam position where it is but blanks it at once
        if (cmd.abort && state_q != StIdle) begin
            state_d  = StIdle;
            z_d      = '0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
            pend_d   = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            blank_q  <= 1'b0;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            int_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            blank_q  <= blank_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            int_q    <= int_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    assign xdac_out      = x_q;
    assign ydac_out      = y_q;
    assign z_out         = z_q;
    assign state_clk_out = strobe_q;
    assign done          = done_q;
    assign busy          = (state_q == StDraw) || (state_q == StSettle);
endmodule

// File: tb/tb_vector_line_gen.sv
// Randomised bench for vector_line_gen: every command is replayed against a
// point-list model and a cycle timeline derived from the command alone.
module tb_vector_line_gen;
    localparam int unsigned CoordW  = 10;
    localparam int unsigned IntW    = 4;
    localparam int          StepDiv = 2;
    localparam int          Settle  = 5;
    localparam int          CMax    = (1 << CoordW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CoordW-1:0] xdac, ydac;
    logic [IntW-1:0]   z;
    logic              strobe, busy, done;

    vector_line_gen_if #(.COORD_W(CoordW), .INT_W(IntW)) bus ();

    vector_line_gen #(
        .COORD_W (CoordW),
        .INT_W   (IntW),
        .STEP_DIV(StepDiv),
        .SETTLE  (Settle)
    ) dut (
        .clkin        (clk),
        .rst_n        (rst_n),
        .cmd          (bus.slave),
        .xdac_out     (xdac),
        .ydac_out     (ydac),
        .z_out        (z),
        .state_clk_out(strobe),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit blank;
        int x0;
        int y0;
        int x1;
        int y1;
        int zi;
    } cmd_t;

    int vec_cnt = 0;
    int mis_cnt = 0;
    int px[$];
    int py[$];
    int last_x = 0;
    int last_y = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic cmd_t mk(input bit b, input int x0, input int y0, input int x1,
                                input int y1, input int zi);
        cmd_t c;
        c.blank = b; c.x0 = x0; c.y0 = y0; c.x1 = x1; c.y1 = y1; c.zi = zi;
        return c;
    endfunction

    // Expected point list straight from the line rules, in plain integers
    function automatic void build(input cmd_t c);
        int dx, dy, sx, sy, err, e2, x, y;
        px.delete();
        py.delete();
        if (c.blank) begin
            px.push_back(c.x1);
            py.push_back(c.y1);
            return;
        end
        dx = iabs(c.x1 - c.x0);
        dy = -iabs(c.y1 - c.y0);
        sx = (c.x1 >= c.x0) ? 1 : -1;
        sy = (c.y1 >= c.y0) ? 1 : -1;
        err = dx + dy;
        x = c.x0;
        y = c.y0;
        for (int n = 0; n < 4096; n++) begin
            px.push_back(x);
            py.push_back(y);
            if (x == c.x1 && y == c.y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > CMax) ? CMax : v);
    endfunction

    function automatic int pick();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return CMax;
            default: return int'($urandom_range(0, CMax));
        endcase
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.blank = ($urandom_range(0, 3) == 0);
        c.x0 = pick();
        c.y0 = pick();
        c.x1 = clampc(c.x0 + int'($urandom_range(0, 60)) - 30);
        c.y1 = clampc(c.y0 + int'($urandom_range(0, 60)) - 30);
        c.zi = int'($urandom_range(1, (1 << IntW) - 1));
        return c;
    endfunction

    task automatic drive(input cmd_t c);
        bus.cmd_blank = c.blank;
        bus.cmd_x0    = CoordW'(c.x0);
        bus.cmd_y0    = CoordW'(c.y0);
        bus.cmd_x1    = CoordW'(c.x1);
        bus.cmd_y1    = CoordW'(c.y1);
        bus.cmd_int   = IntW'(c.zi);
    endtask

    task automatic start(input cmd_t c);
        @(negedge clk);
        drive(c);
        bus.cmd_valid = 1'b1;
    endtask

    // Called just before accept edge A with c on the bus; returns at the
    // negedge of the done cycle (or of the cycle after the abort edge).
    task automatic run(input cmd_t c, input bit chain, input cmd_t nxt, input int abort_k);
        int n_exp, done_k, end_k, idx, ex, ey, nstr;
        bit ab, e_str;
        build(c);
        n_exp  = c.blank ? 1 : ((iabs(c.x1 - c.x0) > iabs(c.y1 - c.y0)) ?
                 iabs(c.x1 - c.x0) : iabs(c.y1 - c.y0)) + 1;
        done_k = c.blank ? 2 + Settle : 2 + n_exp * StepDiv;
        end_k  = (abort_k >= 0) ? abort_k + 1 : done_k;
        nstr   = 0;
        check_eq("ready_pre", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        if (chain) begin
            drive(nxt);
            bus.cmd_valid = 1'b1;
        end else begin
            drive(rand_cmd());
            bus.cmd_valid = 1'b0;
        end
        for (int k = 0; k <= end_k; k++) begin
            @(negedge clk);
            ab = (abort_k >= 0) && (k == abort_k + 1);
            ex = last_x;
            ey = last_y;
            if (k >= 2 && !ab) begin
                idx = c.blank ? 0 : (k - 2) / StepDiv;
                if (idx >= px.size()) idx = px.size() - 1;
                ex = px[idx];
                ey = py[idx];
            end
            e_str = !ab && k >= 2 && k < done_k &&
                    (c.blank ? (k == 2) : ((k - 2) % StepDiv == 0));
            if (strobe) nstr++;
            check_eq($sformatf("x k=%0d", k), xdac, ex);
            check_eq($sformatf("y k=%0d", k), ydac, ey);
            check_eq($sformatf("z k=%0d", k), z,
                     (!c.blank && !ab && k >= 2 && k < done_k) ? c.zi : 0);
            check_eq($sformatf("strobe k=%0d", k), strobe, e_str);
            check_eq($sformatf("busy k=%0d", k), busy, !ab && k >= 1 && k < done_k);
            check_eq($sformatf("done k=%0d", k), done, !ab && k == done_k);
            check_eq($sformatf("ready k=%0d", k), bus.cmd_ready, !ab && k == done_k);
            last_x = ex;
            last_y = ey;
            if (k == abort_k) bus.abort = 1'b1;
        end
        if (abort_k < 0) check_eq("nstrobe", nstr, n_exp);
    endtask

    initial begin
        cmd_t a, b, cur, nxt;
        bit   ch;
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0));

        #12;
        check_eq("rst_x", xdac, 0);
        check_eq("rst_y", ydac, 0);
        check_eq("rst_z", z, 0);
        check_eq("rst_strobe", strobe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("ready_after_rst", bus.cmd_ready, 1);

        // Reset in the middle of a line
        start(mk(0, 5, 7, 20, 7, 9));
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_x", xdac, 5);
        check_eq("mid_y", ydac, 7);
        check_eq("mid_z", z, 9);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_x", xdac, 0);
        check_eq("arst_y", ydac, 0);
        check_eq("arst_z", z, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("arst_ready", bus.cmd_ready, 1);
        repeat (6) begin
            @(negedge clk);
            check_eq("arst_nodone", done, 0);
            check_eq("arst_nostrobe", strobe, 0);
        end
        last_x = 0;
        last_y = 0;

        // Directed lines, zero-length and blank move
        a = mk(0, 0, 0, 3, 1, 9);          start(a); run(a, 0, a, -1);
        a = mk(0, CMax, 0, CMax - 3, CMax, 5); start(a); run(a, 0, a, -1);
        a = mk(0, 100, 100, 100, 100, 7);  start(a); run(a, 0, a, -1);
        a = mk(1, 3, 3, 512, 300, 15);     start(a); run(a, 0, a, -1);

        // Abort on the third point, then abort blocking acceptance in idle
        a = mk(0, 0, 0, 10, 0, 6);         start(a); run(a, 0, a, 2 + 2 * StepDiv);
        drive(mk(0, 1, 1, 8, 8, 3));
        bus.cmd_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("abort_idle_ready", bus.cmd_ready, 0);
            check_eq("abort_idle_busy", busy, 0);
            check_eq("abort_idle_strobe", strobe, 0);
            check_eq("abort_idle_x", xdac, 2);
        end
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;

        // Back-to-back with valid held high
        a = mk(0, 10, 20, 14, 17, 4);
        b = mk(0, 14, 17, 9, 23, 11);
        start(a);
        run(a, 1, b, -1);
        run(b, 0, b, -1);

        // Random commands, randomly chained
        cur = rand_cmd();
        start(cur);
        for (int i = 0; i < 24; i++) begin
            nxt = rand_cmd();
            ch  = ($urandom_range(0, 1) == 1);
            run(cur, ch, nxt, -1);
            if (!ch) start(nxt);
            cur = nxt;
        end
        run(cur, 0, cur, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end
endmodule

// File: doc/vector_line_gen.md
Name: vector_line_gen

Overview:
Parametrised successor to the vectorgen XY beam driver. Accepts one line-draw or blank-move command at a time over a valid/ready handshake. Steps a Bresenham walk from (x0,y0) to (x1,y1), presenting one point per STEP_DIV clocks on full-width X/Y DAC buses with a Z (intensity) output. Sits between the display-list fetcher and the DAC output registers; state_clk_out strobes the DAC latch on each new point.

Parameters:
COORD_W, 10, width of X/Y coordinates and DAC buses (4..16)
INT_W, 4, width of beam intensity
STEP_DIV, 4, clocks each drawn point is held (>=1)
SETTLE, 16, clocks held after a blank move before done (>=1)

Ports:
clkin  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_blank  in  1  1 = blank move (beam off), 0 = draw line
cmd_x0  in  COORD_W  start X, unsigned
cmd_y0  in  COORD_W  start Y, unsigned
cmd_x1  in  COORD_W  end X, unsigned
cmd_y1  in  COORD_W  end Y, unsigned
cmd_int  in  INT_W  intensity for draw
abort  in  1  cancel current command
xdac_out  out  COORD_W  X DAC value
ydac_out  out  COORD_W  Y DAC value
z_out  out  INT_W  beam intensity, 0 = blanked
state_clk_out  out  1  one-cycle strobe when a new point is presented
busy  out  1  command in progress
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; xdac_out=0, ydac_out=0, z_out=0, state_clk_out=0, busy=0, done=0; all internal counters and error terms cleared. Reset asserted mid-line takes effect immediately; no done pulse.
- cmd_ready = (state==IDLE) && !abort, combinational. Accept on rising edge with cmd_valid && cmd_ready (edge A). Command fields are latched at A; later input changes are ignored.
- States: IDLE -> SETUP -> DRAW -> IDLE for draws; IDLE -> SETUP -> SETTLE -> IDLE for blank moves.
- SETUP (one cycle after A): dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1 or -1 (+1 when equal), err=dx+dy. Signed width COORD_W+2; no overflow is possible at any COORD_W.
- DRAW: first point (x0,y0) is driven at A+2 with z_out=cmd_int and state_clk_out=1 for that cycle.
- Each point is held STEP_DIV cycles. Then e2=2*err:
  - if e2>=dy: err+=dy, x+=sx
  - if e2<=dx: err+=dx, y+=sy
  - both updates use the pre-update err.
- The new point is driven with a state_clk_out strobe. Point count is max(dx,|dy|)+1, and the final point is exactly (x1,y1).
- After the final point's STEP_DIV hold: done=1 for one cycle, busy=0, z_out=0, state returns to IDLE. Total: done at A+2+N*STEP_DIV.
- Zero-length line (x0==x1, y0==y1): one point only; done at A+2+STEP_DIV.
- Blank move: at A+2 drive (x1,y1) with z_out=0 and a state_clk_out strobe. Hold SETTLE cycles, then done at A+2+SETTLE. x0/y0 and cmd_int are ignored.
- busy=1 from A+1 until the cycle done asserts; busy=0 in IDLE.
- abort=1 in any non-IDLE state: on the next edge go to IDLE, z_out=0, no done pulse. xdac_out/ydac_out hold their current value. abort in IDLE has no effect except blocking acceptance.
- IDLE: xdac_out/ydac_out hold the last point, z_out=0, state_clk_out=0.
- Coordinates never wrap: the walk terminates exactly at the endpoint, including at 0 and 2^COORD_W-1.

Test Plan:
- Reset then idle: rst_n low mid-line with outputs at (5,7), z=9 -> outputs 0 immediately, cmd_ready=1 after release, no done.
- Draw (0,0)->(3,1), int=9, STEP_DIV=2 -> points (0,0),(1,0),(2,1),(3,1) at A+2/4/6/8, z=9, 4 strobes, done at A+10.
- Draw (1023,0)->(1020,1023) with COORD_W=10 -> 1024 points, final (1020,1023), no wrap, sx=-1, done at A+2+1024*STEP_DIV.
- Zero-length draw (100,100)->(100,100) -> one strobe, done at A+2+STEP_DIV; blank move to (512,300) -> (512,300) at A+2, z=0, done at A+2+SETTLE.
- Abort on 3rd point of (0,0)->(10,0) -> IDLE next edge, x held at 2, z=0, no done; cmd_valid with abort=1 in IDLE -> not accepted.
- Back-to-back commands with cmd_valid held high -> second accepted the cycle after the first done; no point is skipped or duplicated.
